// File: rtl/and_reduce_pipe_pkg.sv
// Shared constants and tree-shape helpers for the fractional-TCAM AND-reduction pipeline.
package fractcam_pkg;

  localparam int FANIN = 6;

  function automatic int levels(input int n);
    int l = 1;
    int cap = FANIN;
    while (cap < n) begin
      cap = cap * FANIN;
      l++;
    end
    return l;
  endfunction

  // Input vector count seen by level j (0-based); groups(n, levels(n)) is always 1.
  function automatic int groups(input int n, input int j);
    int cnt = n;
    for (int i = 0; i < j; i++) cnt = (cnt + FANIN - 1) / FANIN;
    return cnt;
  endfunction

endpackage

// File: rtl/and_reduce_pipe_if.sv
// Valid/ready match-vector stream for and_reduce_pipe; the hit outputs
// exist only when FRACTCAM_HIT_EN is defined.
interface and_reduce_pipe_if #(
  parameter int D     = 64,
  parameter int N     = 8,
  parameter int TAG_W = 8
);
  logic [N*D-1:0]   s_match;
  logic [TAG_W-1:0] s_tag;
  logic             s_valid;
  logic             s_ready;
  logic [D-1:0]     m_match;
  logic [TAG_W-1:0] m_tag;
  logic             m_valid;
  logic             m_ready;
`ifdef FRACTCAM_HIT_EN
  logic                 m_hit;
  logic [$clog2(D)-1:0] m_hit_idx;

  modport slave (
    input  s_match, s_tag, s_valid, m_ready,
    output s_ready, m_match, m_tag, m_valid, m_hit, m_hit_idx
  );
  modport master (
    output s_match, s_tag, s_valid, m_ready,
    input  s_ready, m_match, m_tag, m_valid, m_hit, m_hit_idx
  );
`else
  modport slave (
    input  s_match, s_tag, s_valid, m_ready,
    output s_ready, m_match, m_tag, m_valid
  );
  modport master (
    output s_match, s_tag, s_valid, m_ready,
    input  s_ready, m_match, m_tag, m_valid
  );
`endif
endinterface

// File: rtl/and_reduce_pipe_level.sv
// One registered tree level: ANDs its inputs in groups of FANIN (short group
// padded with all-ones) and holds data/tag/valid under a bubble-collapsing ready.
module and_reduce_level
  import fractcam_pkg::*;
#(
  parameter int D       = 64,
  parameter int IN_CNT  = 6,
  parameter int TAG_W   = 8,
  localparam int OUT_CNT = (IN_CNT + FANIN - 1) / FANIN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_CNT*D-1:0]  in_data,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_CNT*D-1:0] out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [OUT_CNT*FANIN*D-1:0] padded;
  logic [OUT_CNT*D-1:0]       and_next;

  always_comb begin
    padded = '1;
    padded[IN_CNT*D-1:0] = in_data;
  end

  always_comb begin
    and_next = '1;
    for (int g = 0; g < OUT_CNT; g++) begin
      for (int k = 0; k < FANIN; k++) begin
        and_next[g*D +: D] = and_next[g*D +: D] & padded[(g*FANIN+k)*D +: D];
      end
    end
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= and_next;
        out_tag  <= in_tag;
      end
    end
  end

endmodule

// File: rtl/and_reduce_pipe.sv
// Pipelined, back-pressured AND reduction of N sub-match vectors into one D-bit match.
// Defining FRACTCAM_HIT_EN appends a registered hit / lowest-set-index stage.
module and_reduce_pipe
  import fractcam_pkg::*;
#(
  parameter int D     = 64,
  parameter int N     = 8,
  parameter int TAG_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  and_reduce_pipe_if.slave bus
);

  localparam int L = levels(N);

  if (D % 4 != 0) begin : g_bad_d
    $error("and_reduce_pipe: D=%0d is not a multiple of 4", D);
  end
  if (N < 1 || N > 216) begin : g_bad_n
    $error("and_reduce_pipe: N=%0d outside 1..216", N);
  end

  // Index j is the input side of level j+1; index L feeds the output stage.
  logic [TAG_W-1:0] tag_a   [0:L];
  logic             valid_a [0:L];
  logic             ready_a [0:L];
  logic [D-1:0]     tree_data;

  assign tag_a[0]    = bus.s_tag;
  assign valid_a[0]  = bus.s_valid;
  assign bus.s_ready = ready_a[0];

  for (genvar j = 0; j < L; j++) begin : g_lvl
    localparam int IN_CNT  = groups(N, j);
    localparam int OUT_CNT = groups(N, j + 1);
    logic [IN_CNT*D-1:0]  din;
    logic [OUT_CNT*D-1:0] q;

    if (j == 0) begin : g_head
      assign din = bus.s_match;
    end else begin : g_link
      assign din = g_lvl[j-1].q;
    end

    and_reduce_level #(
      .D      (D),
      .IN_CNT (IN_CNT),
      .TAG_W  (TAG_W)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .in_data   (din),
      .in_tag    (tag_a[j]),
      .in_valid  (valid_a[j]),
      .in_ready  (ready_a[j]),
      .out_data  (q),
      .out_tag   (tag_a[j+1]),
      .out_valid (valid_a[j+1]),
      .out_ready (ready_a[j+1])
    );
  end

  assign tree_data = g_lvl[L-1].q;

`ifdef FRACTCAM_HIT_EN
  localparam int IDX_W = $clog2(D);
  logic [IDX_W-1:0] idx_next;

  // Descending scan so the lowest set bit wins.
  always_comb begin
    idx_next = '0;
    for (int i = D - 1; i >= 0; i--) begin
      if (tree_data[i]) idx_next = IDX_W'(i);
    end
  end

  assign ready_a[L] = !bus.m_valid || bus.m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_valid   <= 1'b0;
      bus.m_match   <= '0;
      bus.m_tag     <= '0;
      bus.m_hit     <= 1'b0;
      bus.m_hit_idx <= '0;
    end else if (ready_a[L]) begin
      bus.m_valid <= valid_a[L];
      if (valid_a[L]) begin
        bus.m_match   <= tree_data;
        bus.m_tag     <= tag_a[L];
        bus.m_hit     <= |tree_data;
        bus.m_hit_idx <= idx_next;
      end
    end
  end
`else
  assign bus.m_match = tree_data;
  assign bus.m_tag   = tag_a[L];
  assign bus.m_valid = valid_a[L];
  assign ready_a[L]  = !valid_a[L] || bus.m_ready;
`endif

endmodule

// File: tb/tb_and_reduce_pipe.sv
// Scoreboard bench for and_reduce_pipe: four instances (N=1,6,8,37) share stimulus,
// one is selected at a time; expected results are queued at input transfer.
module tb_and_reduce_pipe;

`ifdef FRACTCAM_HIT_EN
  localparam int HIT = 1;
`else
  localparam int HIT = 0;
`endif

  typedef struct {
    logic [63:0] m;
    logic [7:0]  t;
    int          c;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [37*64-1:0]  big = '0;
  logic [7:0]        tag = 8'h00;
  logic              s_valid = 1'b0;
  logic              m_ready = 1'b0;
  int                sel = 0;
  int                checks = 0;
  int                errors = 0;
  exp_t              q[$];

  logic        o_valid, o_sready;
  logic [63:0] o_match;
  logic [7:0]  o_tag;
  logic        o_hit;
  logic [5:0]  o_idx;

  always #5 clk = ~clk;

  and_reduce_pipe_if #(.D(64), .N(1),  .TAG_W(8)) if1 ();
  and_reduce_pipe_if #(.D(64), .N(6),  .TAG_W(8)) if6 ();
  and_reduce_pipe_if #(.D(64), .N(8),  .TAG_W(8)) if8 ();
  and_reduce_pipe_if #(.D(64), .N(37), .TAG_W(8)) if37 ();

  assign if1.s_match  = big[63:0];
  assign if6.s_match  = big[6*64-1:0];
  assign if8.s_match  = big[8*64-1:0];
  assign if37.s_match = big;
  assign if1.s_tag  = tag;
  assign if6.s_tag  = tag;
  assign if8.s_tag  = tag;
  assign if37.s_tag = tag;
  assign if1.s_valid  = s_valid && (sel == 0);
  assign if6.s_valid  = s_valid && (sel == 1);
  assign if8.s_valid  = s_valid && (sel == 2);
  assign if37.s_valid = s_valid && (sel == 3);
  assign if1.m_ready  = m_ready;
  assign if6.m_ready  = m_ready;
  assign if8.m_ready  = m_ready;
  assign if37.m_ready = m_ready;

  and_reduce_pipe #(.D(64), .N(1),  .TAG_W(8)) u1  (.clk(clk), .rst(rst), .bus(if1));
  and_reduce_pipe #(.D(64), .N(6),  .TAG_W(8)) u6  (.clk(clk), .rst(rst), .bus(if6));
  and_reduce_pipe #(.D(64), .N(8),  .TAG_W(8)) u8  (.clk(clk), .rst(rst), .bus(if8));
  and_reduce_pipe #(.D(64), .N(37), .TAG_W(8)) u37 (.clk(clk), .rst(rst), .bus(if37));

  always_comb begin
    o_valid = 1'b0; o_sready = 1'b0; o_match = '0; o_tag = '0; o_hit = 1'b0; o_idx = '0;
    case (sel)
      0: begin o_valid = if1.m_valid;  o_sready = if1.s_ready;  o_match = if1.m_match;  o_tag = if1.m_tag;  end
      1: begin o_valid = if6.m_valid;  o_sready = if6.s_ready;  o_match = if6.m_match;  o_tag = if6.m_tag;  end
      2: begin o_valid = if8.m_valid;  o_sready = if8.s_ready;  o_match = if8.m_match;  o_tag = if8.m_tag;  end
      default: begin o_valid = if37.m_valid; o_sready = if37.s_ready; o_match = if37.m_match; o_tag = if37.m_tag; end
    endcase
`ifdef FRACTCAM_HIT_EN
    case (sel)
      0: begin o_hit = if1.m_hit;  o_idx = if1.m_hit_idx;  end
      1: begin o_hit = if6.m_hit;  o_idx = if6.m_hit_idx;  end
      2: begin o_hit = if8.m_hit;  o_idx = if8.m_hit_idx;  end
      default: begin o_hit = if37.m_hit; o_idx = if37.m_hit_idx; end
    endcase
`endif
  end

  function automatic int n_of(input int s);
    case (s) 0: return 1; 1: return 6; 2: return 8; default: return 37; endcase
  endfunction

  function automatic int lat_of(input int s);
    case (s) 0: return 1 + HIT; 1: return 1 + HIT; 2: return 2 + HIT; default: return 3 + HIT; endcase
  endfunction

  function automatic logic [63:0] model_and(input int n);
    logic [63:0] acc = '1;
    for (int i = 0; i < n; i++) acc = acc & big[i*64 +: 64];
    return acc;
  endfunction

  function automatic logic [5:0] model_idx(input logic [63:0] v);
    for (int i = 0; i < 64; i++) if (v[i]) return 6'(i);
    return 6'd0;
  endfunction

  // Sparse zeros so a 37-way AND still leaves most bits set.
  task automatic fill_random();
    logic [63:0] z;
    for (int i = 0; i < 37; i++) begin
      z = '1;
      repeat (8) z = z & {$urandom, $urandom};
      big[i*64 +: 64] = ~z;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid sel=%0d got=%b exp=0", s, o_valid); end
      checks++; if (o_match !== 64'h0) begin errors++; $display("FAIL reset_match sel=%0d got=%h exp=0", s, o_match); end
      checks++; if (o_tag !== 8'h0) begin errors++; $display("FAIL reset_tag sel=%0d got=%h exp=0", s, o_tag); end
      checks++; if (o_sready !== 1'b1) begin errors++; $display("FAIL reset_sready sel=%0d got=%b exp=1", s, o_sready); end
`ifdef FRACTCAM_HIT_EN
      checks++; if (o_hit !== 1'b0 || o_idx !== 6'd0) begin errors++; $display("FAIL reset_hit sel=%0d got=%b/%0d exp=0/0", s, o_hit, o_idx); end
`endif
    end
  endtask

  // Single beat into an empty pipe with m_ready=1; big must already hold the vectors.
  task automatic directed_beat(input int s, input logic [7:0] t, input string name);
    int lat;
    logic [63:0] em;
    lat = lat_of(s);
    em = model_and(n_of(s));
    sel = s; m_ready = 1'b1;
    @(posedge clk); #1;
    tag = t; s_valid = 1'b1;
    @(negedge clk);
    checks++; if (o_sready !== 1'b1) begin errors++; $display("FAIL %s_sready got=%b exp=1", name, o_sready); end
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk); #1;
      if (c == 1) s_valid = 1'b0;
      @(negedge clk);
      checks++; if (o_valid !== 1'(c == lat)) begin errors++; $display("FAIL %s_valid cycle=%0d got=%b exp=%b", name, c, o_valid, c == lat); end
      if (c == lat) begin
        checks++; if (o_match !== em) begin errors++; $display("FAIL %s_match got=%h exp=%h", name, o_match, em); end
        checks++; if (o_tag !== t) begin errors++; $display("FAIL %s_tag got=%h exp=%h", name, o_tag, t); end
`ifdef FRACTCAM_HIT_EN
        checks++; if (o_hit !== (|em)) begin errors++; $display("FAIL %s_hit got=%b exp=%b", name, o_hit, |em); end
        checks++; if (o_idx !== model_idx(em)) begin errors++; $display("FAIL %s_hit_idx got=%0d exp=%0d", name, o_idx, model_idx(em)); end
`endif
      end
    end
  endtask

  task automatic test_directed_n6();
    big = '1;
    big[3*64 +: 64] = 64'h0000_0000_0000_00F0;
    directed_beat(1, 8'h5A, "n6");
  endtask

  task automatic test_hit_n1();
    big[63:0] = 64'h0000_0000_0001_0000;
    directed_beat(0, 8'h21, "n1_bit16");
    big[63:0] = 64'h0;
    directed_beat(0, 8'h22, "n1_zero");
  endtask

  task automatic run_stream(input int s, input int count, input int vpct, input int rpct,
                            input bit chk_lat, input string name);
    int sent = 0, guard = 0, cyc = 0, n, lat;
    bit took = 1'b0;
    exp_t e;
    n = n_of(s); lat = lat_of(s);
    sel = s; q.delete(); s_valid = 1'b0;
    while ((sent < count || q.size() != 0) && guard < 3000) begin
      @(posedge clk); #1;
      guard++; cyc++;
      if (!s_valid || took) begin
        took = 1'b0;
        if (sent < count && $urandom_range(99) < vpct) begin
          fill_random(); tag = tag + 8'd1; s_valid = 1'b1;
        end else s_valid = 1'b0;
      end
      m_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (s_valid && o_sready) begin
        q.push_back('{model_and(n), tag, cyc}); sent++; took = 1'b1;
      end
      if (o_valid && m_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL %s_extra_beat got tag=%h exp=none", name, o_tag); end
        else begin
          e = q.pop_front();
          if (o_match !== e.m) begin errors++; $display("FAIL %s_match got=%h exp=%h", name, o_match, e.m); end
          checks++; if (o_tag !== e.t) begin errors++; $display("FAIL %s_tag got=%h exp=%h", name, o_tag, e.t); end
          if (chk_lat) begin
            checks++; if (cyc - e.c != lat) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, cyc - e.c, lat); end
          end
`ifdef FRACTCAM_HIT_EN
          checks++; if (o_hit !== (|e.m) || o_idx !== model_idx(e.m)) begin errors++; $display("FAIL %s_hit got=%b/%0d exp=%b/%0d", name, o_hit, o_idx, |e.m, model_idx(e.m)); end
`endif
        end
      end
    end
    s_valid = 1'b0;
    checks++; if (guard >= 3000) begin errors++; $display("FAIL %s_timeout got sent=%0d pending=%0d exp=drained", name, sent, q.size()); end
    m_ready = 1'b1;
    repeat (lat + 2) begin
      @(negedge clk);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL %s_duplicate got valid=%b tag=%h exp=0", name, o_valid, o_tag); end
    end
  endtask

  task automatic test_stall_n8();
    int acc = 0, cap;
    bit took = 1'b0;
    logic [63:0] hm;
    logic [7:0] ht;
    exp_t e;
    cap = lat_of(2);
    sel = 2; q.delete(); m_ready = 1'b0; s_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (!s_valid || took) begin fill_random(); tag = tag + 8'd1; s_valid = 1'b1; took = 1'b0; end
      @(negedge clk);
      if (s_valid && o_sready) begin q.push_back('{model_and(8), tag, 0}); acc++; took = 1'b1; end
    end
    checks++; if (acc != cap) begin errors++; $display("FAIL stall_accepted got=%0d exp=%0d", acc, cap); end
    checks++; if (o_sready !== 1'b0) begin errors++; $display("FAIL stall_sready got=%b exp=0", o_sready); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b exp=1", o_valid); end
    hm = o_match; ht = o_tag;
    repeat (3) begin
      @(negedge clk);
      checks++; if (o_match !== hm || o_tag !== ht) begin errors++; $display("FAIL stall_stable got=%h/%h exp=%h/%h", o_match, o_tag, hm, ht); end
    end
    @(posedge clk); #1;
    m_ready = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    checks++; if (o_sready !== 1'b1) begin errors++; $display("FAIL stall_sready_rise got=%b exp=1", o_sready); end
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      if (c > 0) @(negedge clk);
      if (o_valid && m_ready) begin
        e = q.pop_front();
        checks++; if (o_match !== e.m || o_tag !== e.t) begin errors++; $display("FAIL stall_drain got=%h/%h exp=%h/%h", o_match, o_tag, e.m, e.t); end
      end
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL stall_lost got pending=%0d exp=0", q.size()); end
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stall_after_drain got=%b exp=0", o_valid); end
  endtask

  task automatic test_reset_midstream();
    sel = 2; m_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      fill_random(); tag = tag + 8'd1; s_valid = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", o_valid); end
    checks++; if (o_match !== 64'h0) begin errors++; $display("FAIL midrst_match got=%h exp=0", o_match); end
    @(posedge clk); #1;
    rst = 1'b0; m_ready = 1'b1;
    #1;
    checks++; if (o_sready !== 1'b1) begin errors++; $display("FAIL midrst_sready got=%b exp=1", o_sready); end
    repeat (6) begin
      @(negedge clk);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_ghost got valid=%b tag=%h exp=0", o_valid, o_tag); end
    end
    fill_random();
    directed_beat(2, 8'hC3, "post_rst");
  endtask

  initial begin
    test_reset();
    test_directed_n6();
    test_hit_n1();
    run_stream(2, 20, 100, 100, 1'b1, "stream_n8");
    test_stall_n8();
    run_stream(3, 40, 50, 60, 1'b0, "bubbly_n37");
    run_stream(0, 12, 70, 70, 1'b0, "bubbly_n1");
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
